nes_frame_player: RTL and testbench

- Replays a stored 256x240 NES frame as a live PPU-style pixel stream: 6-bit color plus cycle and scanline.
- It is the producer end of the NES video interface that the HDMI converter consumes.
- It stands in for the PPU in bring-up, loopback and frame-buffer replay builds.
- It fetches pixels from an external memory through a req/ack port, buffers them in a small FIFO, and emits them with NES dot timing.

---
 rtl/nes_frame_player.sv | 239 +++++++++++++++++++++++
 tb/tb_nes_frame_player.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_frame_player.sv
// nes_frame_player: replays a stored frame as a live NES PPU-style dot stream.
// Pixels are fetched over a req/ack port into a small FIFO and emitted one
// per dot (CLK_DIV clocks) with NES cycle/scanline timing.
// VIS_W/VIS_H size the visible window (256x240 for a real NES frame).
// Optional feature: define NES_FRAME_PLAYER_ODD_SKIP_EN to drop the last dot
// of line LINES_PER_FRAME-1 on odd frames (NES odd-frame skip).
module nes_frame_player #(
    parameter int CLK_DIV         = 4,
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int FIFO_DEPTH      = 16,
    parameter int BORDER_COLOR    = 13,
    parameter int VIS_W           = 256,
    parameter int VIS_H           = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [5:0]  mem_rdata,
    output logic [5:0]  color,
    output logic [8:0]  cycle,
    output logic [8:0]  scanline,
    output logic        frame_start,
    output logic        underrun
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [5:0]       BORDER    = 6'(BORDER_COLOR);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [8:0]       LAST_DOT  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0]       LAST_LINE = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0]       VIS_W9    = 9'(VIS_W);
    localparam logic [8:0]       VIS_H9    = 9'(VIS_H);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [8:0]       cycle_q, cycle_d;
    logic [8:0]       scanline_q, scanline_d;
    logic [5:0]       color_q, color_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q, underrun_d;
    logic             mem_req_q, mem_req_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic [8:0]       fetch_x_q, fetch_x_d;
    logic [8:0]       fetch_y_q, fetch_y_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [5:0]       fifo_mem [FIFO_DEPTH];

`ifdef NES_FRAME_PLAYER_ODD_SKIP_EN
    logic             parity_q, parity_d;
`endif

    logic       tick, line_end, nxt_vis, fifo_empty, fifo_full;
    logic       flush, frame_tick, pop, push, ack, fetch_done;
    logic [8:0] nxt_cycle, nxt_line;

    // Next-state logic: dot timing, pixel pop, fetch FSM and FIFO bookkeeping.
    always_comb begin
        // dot divider
        tick  = enable && (div_q == DIV_LAST);
        div_d = div_q;
        if (enable) div_d = tick ? '0 : div_q + 1'b1;

        // position the next tick lands on
        line_end = (cycle_q == LAST_DOT);
`ifdef NES_FRAME_PLAYER_ODD_SKIP_EN
        if (parity_q && scanline_q == LAST_LINE && cycle_q == LAST_DOT - 9'd1)
            line_end = 1'b1;
`endif
        nxt_cycle = line_end ? 9'd0 : cycle_q + 9'd1;
        nxt_line  = scanline_q;
        if (line_end) nxt_line = (scanline_q == LAST_LINE) ? 9'd0 : scanline_q + 9'd1;
        nxt_vis   = (nxt_line < VIS_H9) && (nxt_cycle < VIS_W9);

        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FIFO_FULL);
        flush      = tick && (nxt_line == LAST_LINE) && (nxt_cycle == 9'd0);
        frame_tick = tick && (nxt_line == 9'd0) && (nxt_cycle == 9'd0);
        pop        = tick && nxt_vis && !fifo_empty;
        ack        = mem_ack && mem_req_q;
        fetch_done = (fetch_y_q >= VIS_H9);

        // Position and color move together on the tick. After reset the
        // position rests on (0,0) without a tick, so the first frame is shown
        // one dot late; the flush before every later frame realigns it.
        cycle_d       = cycle_q;
        scanline_d    = scanline_q;
        color_d       = color_q;
        underrun_d    = underrun_q;
        frame_start_d = frame_tick;
        if (tick) begin
            cycle_d    = nxt_cycle;
            scanline_d = nxt_line;
            color_d    = pop ? fifo_mem[rd_ptr_q] : BORDER;
            if (nxt_vis && fifo_empty) underrun_d = 1'b1;
        end

`ifdef NES_FRAME_PLAYER_ODD_SKIP_EN
        parity_d = parity_q ^ frame_tick;
`endif

        // fetch FSM
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fetch_x_d  = fetch_x_q;
        fetch_y_d  = fetch_y_q;
        push       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (mem_req_q) begin
                    // a pending request always completes, even if enable fell
                    if (ack) begin
                        push      = 1'b1;
                        mem_req_d = 1'b0;
                        if (fetch_x_q == VIS_W9 - 9'd1) begin
                            fetch_x_d = 9'd0;
                            fetch_y_d = fetch_y_q + 9'd1;
                        end else begin
                            fetch_x_d = fetch_x_q + 9'd1;
                        end
                    end
                end else if (!enable) begin
                    state_d = ST_HOLD;
                end else if (!fifo_full && !fetch_done) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {fetch_y_q[7:0], fetch_x_q[7:0]};
                end
            end
            ST_FLUSH: begin
                // wait out a stale request; its data is dropped
                if (!mem_req_q || ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_HOLD: begin
                mem_req_d = 1'b0;
                if (enable) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        // Start of the last line: drop everything buffered for this frame and
        // restart fetching from pixel 0 so the next frame is prefetched.
        if (flush) begin
            state_d    = ST_FLUSH;
            mem_req_d  = mem_req_q && !ack;
            mem_addr_d = mem_addr_q;
            push       = 1'b0;
            fetch_x_d  = 9'd0;
            fetch_y_d  = 9'd0;
        end

        // FIFO pointers and occupancy
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            div_q         <= '0;
            cycle_q       <= 9'd0;
            scanline_q    <= 9'd0;
            color_q       <= BORDER;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 16'd0;
            fetch_x_q     <= 9'd0;
            fetch_y_q     <= 9'd0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
`ifdef NES_FRAME_PLAYER_ODD_SKIP_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            cycle_q       <= cycle_d;
            scanline_q    <= scanline_d;
            color_q       <= color_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            fetch_x_q     <= fetch_x_d;
            fetch_y_q     <= fetch_y_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
`ifdef NES_FRAME_PLAYER_ODD_SKIP_EN
            parity_q      <= parity_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !reset) fifo_mem[wr_ptr_q] <= mem_rdata;
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign color       = color_q;
    assign cycle       = cycle_q;
    assign scanline    = scanline_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_nes_frame_player.sv
// Bench for nes_frame_player on a shrunken raster (20 dots x 12 lines,
// 8x6 visible). Expected position, frame pulses and colors come from a dot
// counter and a pixel function of (y, x); a responder task plays memory.
`timescale 1ns/1ps
module tb_nes_frame_player;

    localparam int CLK_DIV = 4;
    localparam int DOTS    = 20;
    localparam int LINES   = 12;
    localparam int DEPTH   = 8;
    localparam int BORDER  = 13;
    localparam int VW      = 8;
    localparam int VH      = 6;
    localparam int FRAME   = DOTS * LINES;
`ifdef NES_FRAME_PLAYER_ODD_SKIP_EN
    localparam bit ODD_SKIP = 1'b1;
`else
    localparam bit ODD_SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        mem_req, mem_ack, frame_start, underrun;
    logic [15:0] mem_addr;
    logic [5:0]  mem_rdata, color;
    logic [8:0]  cycle, scanline;

    int checks = 0;
    int errors = 0;

    // reference model state
    int div_cnt = 0, dot = 0, frame_idx = 0, m_line = 0, m_cyc = 0, check_from = 1;
    bit fs_exp = 0, exp_ur = 0, ticked = 0, en_edge = 0, prev_req = 0;
    bit starved = 0, loose = 0;
    logic [15:0] prev_addr = 16'd0;

    // memory responder controls
    bit stall = 0, spurious = 0, data_mode = 0;
    int max_lat = 1, seed = 0, wcnt = 0;

    nes_frame_player #(
        .CLK_DIV(CLK_DIV), .DOTS_PER_LINE(DOTS), .LINES_PER_FRAME(LINES),
        .FIFO_DEPTH(DEPTH), .BORDER_COLOR(BORDER), .VIS_W(VW), .VIS_H(VH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .color(color), .cycle(cycle), .scanline(scanline),
        .frame_start(frame_start), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pix(input int y, input int x);
        int v;
        if (data_mode) v = y * 256 + x;
        else           v = y * 37 + x * 11 + seed;
        return 6'(v & 63);
    endfunction

    function automatic int frame_len(input int k);
        int len = FRAME;
        if (ODD_SKIP && (k % 2 == 1)) len = FRAME - 1;
        return len;
    endfunction

    // memory: acks after 0..max_lat extra clocks, optional spurious acks
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 6'd0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            mem_rdata = 6'($urandom);
            if (mem_req && !stall && !starved) begin
                if (wcnt == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = pix(int'(mem_addr[15:8]), int'(mem_addr[7:0]));
                    wcnt = int'($urandom_range(max_lat, 0));
                end else begin
                    wcnt--;
                end
            end else if (!mem_req && spurious && $urandom_range(3, 0) == 0) begin
                mem_ack = 1'b1;
            end
        end
    end

    // one clock: advance the model at the edge, compare at the falling edge
    task automatic step();
        bit vis;
        logic [5:0] exp_c;
        @(posedge clk);
        en_edge = enable;
        fs_exp = 0;
        ticked = 0;
        if (reset) begin
            div_cnt = 0; dot = 0; frame_idx = 0; exp_ur = 0;
        end else if (enable) begin
            div_cnt++;
            if (div_cnt == CLK_DIV) begin
                div_cnt = 0;
                dot++;
                ticked = 1;
                if (dot == frame_len(frame_idx)) begin
                    dot = 0;
                    frame_idx++;
                    fs_exp = 1;
                end
            end
        end
        m_line = dot / DOTS;
        m_cyc  = dot % DOTS;
        vis = (m_line < VH) && (m_cyc < VW);
        if (ticked && vis && starved) exp_ur = 1;
        @(negedge clk);
        checks++;
        if (cycle !== 9'(m_cyc)) begin
            errors++; $display("FAIL cycle got %0d exp %0d (frame %0d dot %0d)", cycle, m_cyc, frame_idx, dot);
        end
        checks++;
        if (scanline !== 9'(m_line)) begin
            errors++; $display("FAIL scanline got %0d exp %0d (frame %0d dot %0d)", scanline, m_line, frame_idx, dot);
        end
        checks++;
        if (frame_start !== fs_exp) begin
            errors++; $display("FAIL frame_start got %0b exp %0b (frame %0d dot %0d)", frame_start, fs_exp, frame_idx, dot);
        end
        if (!loose) begin
            checks++;
            if (underrun !== exp_ur) begin
                errors++; $display("FAIL underrun got %0b exp %0b (frame %0d dot %0d)", underrun, exp_ur, frame_idx, dot);
            end
        end
        if (!vis || starved || (!loose && frame_idx >= check_from)) begin
            exp_c = (!vis || starved) ? 6'(BORDER) : pix(m_line, m_cyc);
            checks++;
            if (color !== exp_c) begin
                errors++; $display("FAIL color at (%0d,%0d) got %0d exp %0d (frame %0d)", m_line, m_cyc, color, exp_c, frame_idx);
            end
        end
        if (mem_req && prev_req) begin
            checks++;
            if (mem_addr !== prev_addr) begin
                errors++; $display("FAIL addr_stable got %h exp %h", mem_addr, prev_addr);
            end
        end
        if (mem_req && !prev_req) begin
            checks++;
            if (!en_edge || int'(mem_addr[15:8]) >= VH || int'(mem_addr[7:0]) >= VW) begin
                errors++; $display("FAIL req_issue addr %h enable %0b exp enable 1 and in-frame address", mem_addr, en_edge);
            end
        end
        prev_req = mem_req;
        prev_addr = mem_addr;
    endtask

    task automatic run_until(input int l, input int c, input int limit);
        int n = 0;
        while (!(m_line == l && m_cyc == c && ticked)) begin
            step();
            n++;
            if (n > limit) begin
                checks++; errors++;
                $display("FAIL timeout waiting for (%0d,%0d) got (%0d,%0d) exp reached", l, c, m_line, m_cyc);
                return;
            end
        end
    endtask

    task automatic run_frames(input int n);
        int tgt = frame_idx + n;
        while (frame_idx < tgt) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        check_from = 1;
        loose = 0;
    endtask

    task automatic test_reset();
        enable = 1'b1; starved = 0; stall = 0; spurious = 0; data_mode = 0; max_lat = 1;
        reset = 1'b1;
        repeat (3) step();
        checks++; if (color !== 6'(BORDER)) begin errors++; $display("FAIL rst_color got %0d exp %0d", color, BORDER); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", mem_req); end
        checks++; if (mem_addr !== 16'd0) begin errors++; $display("FAIL rst_addr got %h exp 0", mem_addr); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %0b exp 0", underrun); end
        reset = 1'b0;
        check_from = 1;
        step();
        if (!mem_req) step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL req_after_reset got %0b exp 1", mem_req); end
        checks++; if (mem_addr !== 16'd0) begin errors++; $display("FAIL first_addr got %h exp 0", mem_addr); end
    endtask

    task automatic test_timing();
        int n, f;
        do_reset();
        n = 0;
        while (frame_start !== 1'b1 && n < 3 * FRAME * CLK_DIV) begin step(); n++; end
        for (int k = 0; k < 3; k++) begin
            f = frame_idx;
            n = 0;
            step(); n++;
            while (frame_start !== 1'b1 && n < 3 * FRAME * CLK_DIV) begin step(); n++; end
            checks++;
            if (n != CLK_DIV * frame_len(f)) begin
                errors++; $display("FAIL frame_period frame %0d got %0d exp %0d", f, n, CLK_DIV * frame_len(f));
            end
        end
    endtask

    task automatic test_data_map();
        data_mode = 1;
        do_reset();
        run_frames(1);
        run_until(2, 5, 4 * FRAME * CLK_DIV);
        checks++; if (color !== pix(2, 5)) begin errors++; $display("FAIL map_2_5 got %0d exp %0d", color, pix(2, 5)); end
        run_until(VH - 1, VW - 1, 4 * FRAME * CLK_DIV);
        checks++; if (color !== pix(VH - 1, VW - 1)) begin errors++; $display("FAIL map_last got %0d exp %0d", color, pix(VH - 1, VW - 1)); end
        run_until(VH, 0, 4 * FRAME * CLK_DIV);
        checks++; if (color !== 6'(BORDER)) begin errors++; $display("FAIL map_border got %0d exp %0d", color, BORDER); end
        data_mode = 0;
    endtask

    task automatic test_random_enable();
        int tgt;
        seed = int'($urandom_range(63, 0));
        spurious = 1;
        do_reset();
        tgt = frame_idx + 3;
        while (frame_idx < tgt) begin
            enable = ($urandom_range(7, 0) != 0);
            step();
        end
        enable = 1'b1;
        spurious = 0;
    endtask

    task automatic test_flush();
        seed = int'($urandom_range(63, 0));
        do_reset();
        run_frames(1);
        run_until(VH - 3, VW, 4 * FRAME * CLK_DIV);
        stall = 1;
        loose = 1;
        run_until(LINES - 1, 5, 4 * FRAME * CLK_DIV);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL flush_req_held got %0b exp 1", mem_req); end
        stall = 0;
        run_until(0, 0, 4 * FRAME * CLK_DIV);
        checks++; if (color !== pix(0, 0)) begin errors++; $display("FAIL flush_first_pixel got %0d exp %0d", color, pix(0, 0)); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL flush_underrun got %0b exp 1", underrun); end
        loose = 0;
        exp_ur = 1;
        check_from = frame_idx;
        run_frames(1);
    endtask

    task automatic test_underrun();
        seed = int'($urandom_range(63, 0));
        starved = 1;
        do_reset();
        run_frames(1);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_at_frame got %0b exp 1", underrun); end
        checks++; if (color !== 6'(BORDER)) begin errors++; $display("FAIL ur_color got %0d exp %0d", color, BORDER); end
        starved = 0;
        check_from = frame_idx + 2;
        run_frames(3);
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky got %0b exp 1", underrun); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        run_frames(1);
        step();
        while (mem_req !== 1'b1 && n < 50) begin step(); n++; end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_seen got %0b exp 1", mem_req); end
        reset = 1'b1;
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_req_drop got %0b exp 0", mem_req); end
        checks++; if (color !== 6'(BORDER)) begin errors++; $display("FAIL mid_color got %0d exp %0d", color, BORDER); end
        reset = 1'b0;
        check_from = 1;
        run_frames(2);
    endtask

    initial begin
        test_reset();
        test_timing();
        test_data_map();
        test_random_enable();
        test_flush();
        test_underrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
